// File: rtl/uart_pkg.sv
// Shared types and constants for the sample UART transmitter.
// Frame and bit-engine state encodings plus UART line levels.
package uart_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_SYNC,
        F_DATA,
        F_DONE
    } frame_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_BITS,
        B_STOP
    } bit_state_t;

    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer with baud counter; accepts a new byte on the
// last cycle of STOP so consecutive bytes leave no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       nRst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    bit_state_t    state;
    bit_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [7:0]    sh;
    logic [7:0]    sh_next;
    logic          tx_next;
    logic          bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state <= B_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            tx    <= UART_STOP;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            sh    <= sh_next;
            tx    <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        sh_next    = sh;
        tx_next    = tx;
        unique case (state)
            B_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = B_START;
                    sh_next    = data;
                    tx_next    = UART_START;
                end
            end
            B_START: begin
                if (bit_end) begin
                    state_next = B_BITS;
                    cnt_next   = '0;
                    idx_next   = '0;
                    tx_next    = sh[0];
                end
            end
            B_BITS: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx == 3'd7) begin
                        state_next = B_STOP;
                        tx_next    = UART_STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                        tx_next  = sh[idx + 3'd1];
                    end
                end
            end
            B_STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (start) begin
                        state_next = B_START;
                        sh_next    = data;
                        tx_next    = UART_START;
                    end else begin
                        state_next = B_IDLE;
                    end
                end
            end
            default: state_next = B_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != B_IDLE);
        byte_done = (state == B_STOP) && bit_end;
    end

endmodule

// File: rtl/sample_uart_tx.sv
// Frames signed samples as SYNC_BYTE followed by little-endian bytes
// and streams them through the byte serializer.
module sample_uart_tx
    import uart_pkg::*;
#(
    parameter int         DATAWIDTH    = 64,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                 Clk,
    input  logic                 nRst,
    input  logic [DATAWIDTH-1:0] SampleIn,
    input  logic                 SampleValid,
    output logic                 SampleReady,
    output logic                 Tx,
    output logic                 Busy,
    output logic                 FrameDone
);

    localparam int NBYTES = DATAWIDTH / 8;
    localparam int BW     = cnt_width(NBYTES);
    localparam logic [BW-1:0] BLAST = BW'(NBYTES - 1);

    generate
        if ((DATAWIDTH % 8) != 0 || DATAWIDTH < 8 || DATAWIDTH > 64)
        begin : g_bad_width
            $error("sample_uart_tx: DATAWIDTH must be 8..64, multiple of 8");
        end
    endgenerate

    frame_state_t         fstate;
    frame_state_t         fnext;
    logic [BW-1:0]        bcnt;
    logic [DATAWIDTH-1:0] shift;
    logic                 accept;
    logic                 more;
    logic                 start;
    logic                 byte_done;
    logic                 eng_busy;
    logic [7:0]           byte_data;

    // The sync byte is handed over on the accept edge so Tx drops next cycle.
    assign accept    = (fstate == F_IDLE) && SampleValid;
    assign more      = (fstate == F_SYNC) ||
                       ((fstate == F_DATA) && (bcnt != BLAST));
    assign start     = accept || (byte_done && more);
    assign byte_data = (fstate == F_IDLE) ? SYNC_BYTE : shift[7:0];

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .Clk      (Clk),
        .nRst     (nRst),
        .start    (start),
        .data     (byte_data),
        .tx       (Tx),
        .busy     (eng_busy),
        .byte_done(byte_done)
    );

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            fstate <= F_IDLE;
        end else begin
            fstate <= fnext;
        end
    end

    always_comb begin
        fnext = fstate;
        unique case (fstate)
            F_IDLE: if (accept) fnext = F_SYNC;
            F_SYNC: if (byte_done) fnext = F_DATA;
            F_DATA: if (byte_done && bcnt == BLAST) fnext = F_DONE;
            F_DONE: fnext = F_IDLE;
            default: fnext = F_IDLE;
        endcase
    end

    // Shift as each byte is handed to the engine, so shift[7:0] is always next.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            shift <= '0;
            bcnt  <= '0;
        end else if (accept) begin
            shift <= SampleIn;
            bcnt  <= '0;
        end else if (byte_done) begin
            if (more) begin
                shift <= shift >> 8;
            end
            if (fstate == F_DATA) begin
                bcnt <= (bcnt == BLAST) ? '0 : bcnt + 1'b1;
            end
        end
    end

    always_comb begin
        SampleReady = (fstate == F_IDLE);
        Busy        = (fstate != F_IDLE) || eng_busy;
        FrameDone   = (fstate == F_DONE);
    end

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed bench for sample_uart_tx: decodes the Tx line bit by bit
// for a 64-bit and a 16-bit instance at 4 clocks per bit.
module tb_sample_uart_tx;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [63:0] s64;
    logic        v64;
    logic        rdy64;
    logic        tx64;
    logic        busy64;
    logic        fd64;
    logic [15:0] s16;
    logic        v16;
    logic        rdy16;
    logic        tx16;
    logic        busy16;
    logic        fd16;
    logic        quiet;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sample_uart_tx #(
        .DATAWIDTH(64), .CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)
    ) dut64 (
        .Clk(clk), .nRst(nrst), .SampleIn(s64), .SampleValid(v64),
        .SampleReady(rdy64), .Tx(tx64), .Busy(busy64), .FrameDone(fd64)
    );

    sample_uart_tx #(
        .DATAWIDTH(16), .CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)
    ) dut16 (
        .Clk(clk), .nRst(nrst), .SampleIn(s16), .SampleValid(v16),
        .SampleReady(rdy16), .Tx(tx16), .Busy(busy16), .FrameDone(fd16)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input bit w16);
        return w16 ? tx16 : tx64;
    endfunction

    task automatic decode(input bit w16, input int nb,
                          input logic [63:0] s, input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        logic       st;
        logic       stop;
        logic       stable;
        logic       early;
        logic       first;
        logic       t;
        early = 1'b0;
        first = 1'b0;
        for (int j = 0; j < nb; j++) begin
            exp    = (j == 0) ? 8'hA5 : s[8*(j-1) +: 8];
            got    = '0;
            st     = 1'b1;
            stop   = 1'b0;
            stable = 1'b1;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < 4; c++) begin
                    t = line(w16);
                    if (c == 0) first = t;
                    else if (t !== first) stable = 1'b0;
                    if (c == 0) begin
                        if (b == 0) st = t;
                        else if (b == 9) stop = t;
                        else got[b-1] = t;
                    end
                    if ((w16 ? fd16 : fd64) === 1'b1) early = 1'b1;
                    tick;
                end
            end
            chk($sformatf("%s b%0d start", tag, j), {63'd0, st}, 64'd0);
            chk($sformatf("%s b%0d stop", tag, j), {63'd0, stop}, 64'd1);
            chk($sformatf("%s b%0d hold", tag, j), {63'd0, stable}, 64'd1);
            chk($sformatf("%s b%0d byte", tag, j), {56'd0, got}, {56'd0, exp});
        end
        chk({tag, " early_done"}, {63'd0, early}, 64'd0);
        chk({tag, " frame_done"}, {63'd0, w16 ? fd16 : fd64}, 64'd1);
    endtask

    task automatic send(input bit w16, input logic [63:0] s, input bit hold,
                        input logic [63:0] nxt, input string tag);
        if (w16) begin
            s16 = s[15:0];
            v16 = 1'b1;
        end else begin
            s64 = s;
            v64 = 1'b1;
        end
        chk({tag, " ready_pre"}, {63'd0, w16 ? rdy16 : rdy64}, 64'd1);
        tick;
        if (hold) begin
            s64 = nxt;
        end else begin
            v64 = 1'b0;
            v16 = 1'b0;
        end
        chk({tag, " busy"}, {63'd0, w16 ? busy16 : busy64}, 64'd1);
        chk({tag, " ready_busy"}, {63'd0, w16 ? rdy16 : rdy64}, 64'd0);
        decode(w16, w16 ? 3 : 9, s, tag);
    endtask

    initial begin
        v64 = 1'b0;
        v16 = 1'b0;
        s64 = '0;
        s16 = '0;
        #2 nrst = 1'b0;
        #1;
        chk("rst_async tx", {63'd0, tx64}, 64'd1);
        chk("rst_async rdy", {63'd0, rdy64}, 64'd1);
        chk("rst_async busy", {63'd0, busy64}, 64'd0);
        chk("rst_async done", {63'd0, fd64}, 64'd0);
        repeat (5) tick;
        nrst = 1'b1;
        tick;
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (tx64 !== 1'b1 || rdy64 !== 1'b1 || busy64 !== 1'b0 ||
                fd64 !== 1'b0 || tx16 !== 1'b1 || busy16 !== 1'b0)
                quiet = 1'b0;
            tick;
        end
        chk("idle_100", {63'd0, quiet}, 64'd1);

        send(1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, "t2");
        tick;
        chk("t2 idle_ready", {63'd0, rdy64}, 64'd1);
        chk("t2 idle_busy", {63'd0, busy64}, 64'd0);

        send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, "t3");
        tick;

        send(1'b0, 64'd1, 1'b1, 64'd2, "t4a");
        tick;
        chk("t4 gap_ready", {63'd0, rdy64}, 64'd1);
        chk("t4 gap_tx", {63'd0, tx64}, 64'd1);
        send(1'b0, 64'd2, 1'b0, 64'd0, "t4b");
        tick;

        s64 = 64'h1122_3344_5500_7788;
        v64 = 1'b1;
        tick;
        v64 = 1'b0;
        repeat (146) tick;
        chk("t5 pre_tx", {63'd0, tx64}, 64'd0);
        chk("t5 pre_busy", {63'd0, busy64}, 64'd1);
        #2 nrst = 1'b0;
        #1;
        chk("t5 rst_tx", {63'd0, tx64}, 64'd1);
        chk("t5 rst_busy", {63'd0, busy64}, 64'd0);
        chk("t5 rst_rdy", {63'd0, rdy64}, 64'd1);
        repeat (2) tick;
        nrst = 1'b1;
        tick;
        send(1'b0, 64'hFEDC_BA98_7654_3210, 1'b0, 64'd0, "t5b");
        tick;

        send(1'b1, 64'h8001, 1'b0, 64'd0, "t6");
        tick;
        chk("t6 idle_ready", {63'd0, rdy16}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
